// File: rtl/mmv_ram_test_sequencer.sv
// Sequencer and port arbiter for memory-mapped RAM testers. Runs NTESTS testers
// back to back, multiplexes the single RAM master port to the active tester and
// aggregates tester fault/done pulses into run status.
`timescale 1ns/1ps
module mmv_ram_test_sequencer #(
    parameter int unsigned AWIDTH        = 8,
    parameter int unsigned DWIDTH        = 8,
    parameter int unsigned NTESTS        = 3,
    parameter int unsigned STOP_ON_FAULT = 1,
    parameter int unsigned FCWIDTH       = 16,
    localparam int unsigned IW           = (NTESTS > 1) ? $clog2(NTESTS) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     start_i,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     fault_o,
    output logic [IW-1:0]            fault_idx_o,
    output logic [FCWIDTH-1:0]       fault_cnt_o,
    output logic [NTESTS-1:0]        t_start_o,
    output logic                     t_clear_o,
    input  logic [NTESTS-1:0]        t_ready_i,
    input  logic [NTESTS-1:0]        t_fault_i,
    input  logic [NTESTS-1:0]        t_done_i,
    input  logic [NTESTS*AWIDTH-1:0] t_addr_i,
    input  logic [NTESTS*DWIDTH-1:0] t_wdat_i,
    input  logic [NTESTS-1:0]        t_wreq_i,
    input  logic [NTESTS-1:0]        t_rreq_i,
    output logic [DWIDTH-1:0]        t_rdat_o,
    output logic [NTESTS-1:0]        t_rval_o,
    output logic [NTESTS-1:0]        t_busy_o,
    output logic [AWIDTH-1:0]        m_addr_o,
    output logic                     m_wreq_o,
    output logic [DWIDTH-1:0]        m_wdat_o,
    output logic                     m_rreq_o,
    input  logic [DWIDTH-1:0]        m_rdat_i,
    input  logic                     m_rval_i,
    input  logic                     m_busy_i
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StAbort,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      cur_q, cur_d;
    logic               fault_q, fault_d;
    logic [IW-1:0]      fault_idx_q, fault_idx_d;
    logic [FCWIDTH-1:0] fault_cnt_q, fault_cnt_d;
    logic               port_on;

    // State and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    // Next-state logic: clear overrides everything, abort beats a same-cycle done.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
        fault_cnt_d = fault_cnt_q;
        if (clear_i) begin
            state_d     = StIdle;
            cur_d       = '0;
            fault_d     = 1'b0;
            fault_idx_d = '0;
            fault_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d     = StLaunch;
                        cur_d       = '0;
                        fault_d     = 1'b0;
                        fault_idx_d = '0;
                        fault_cnt_d = '0;
                    end
                end
                StLaunch: begin
                    if (t_ready_i[cur_q]) state_d = StRun;
                end
                StRun: begin
                    if (t_fault_i[cur_q]) begin
                        if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
                        if (!fault_q) begin
                            fault_d     = 1'b1;
                            fault_idx_d = cur_q;
                        end
                    end
                    if (t_fault_i[cur_q] && (STOP_ON_FAULT != 0)) begin
                        state_d = StAbort;
                    end else if (t_done_i[cur_q]) begin
                        if (cur_q == IW'(NTESTS - 1)) begin
                            state_d = StFinish;
                        end else begin
                            cur_d   = cur_q + 1'b1;
                            state_d = StLaunch;
                        end
                    end
                end
                StAbort:  state_d = StFinish;
                StFinish: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Control outputs and port mux; only the current tester sees the RAM port.
    always_comb begin
        port_on   = (state_q == StLaunch) || (state_q == StRun);
        ready_o   = (state_q == StIdle);
        done_o    = (state_q == StFinish) && !clear_i && !reset_i;
        t_clear_o = !reset_i && (clear_i || (state_q == StAbort));
        t_start_o = '0;
        t_rdat_o  = m_rdat_i;
        t_rval_o  = '0;
        t_busy_o  = '1;
        m_addr_o  = '0;
        m_wdat_o  = '0;
        m_wreq_o  = 1'b0;
        m_rreq_o  = 1'b0;
        for (int i = 0; i < NTESTS; i++) begin
            if (port_on && (cur_q == IW'(i))) begin
                t_start_o[i] = (state_q == StLaunch) && t_ready_i[i] && !clear_i && !reset_i;
                m_addr_o     = t_addr_i[i*AWIDTH +: AWIDTH];
                m_wdat_o     = t_wdat_i[i*DWIDTH +: DWIDTH];
                m_wreq_o     = t_wreq_i[i];
                m_rreq_o     = t_rreq_i[i];
                t_busy_o[i]  = m_busy_i;
                t_rval_o[i]  = m_rval_i;
            end
        end
    end

    assign fault_o     = fault_q;
    assign fault_idx_o = fault_idx_q;
    assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_mmv_ram_test_sequencer.sv
// Bench for mmv_ram_test_sequencer: dut_a aborts on fault (16-bit counter),
// dut_b runs all testers with a 2-bit counter. Both share the stimulus.
`timescale 1ns/1ps
module tb_mmv_ram_test_sequencer;
    localparam int NT = 3;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clear, start;
    logic [NT-1:0]    t_ready, t_fault, t_done, t_wreq, t_rreq;
    logic [NT*AW-1:0] t_addr;
    logic [NT*DW-1:0] t_wdat;
    logic [DW-1:0]    m_rdat;
    logic             m_rval, m_busy;

    logic a_ready, a_done, a_fault, a_t_clear, a_m_wreq, a_m_rreq;
    logic [1:0] a_fault_idx;
    logic [15:0] a_fault_cnt;
    logic [NT-1:0] a_t_start, a_t_rval, a_t_busy;
    logic [DW-1:0] a_t_rdat, a_m_wdat;
    logic [AW-1:0] a_m_addr;

    logic b_ready, b_done, b_fault, b_t_clear, b_m_wreq, b_m_rreq;
    logic [1:0] b_fault_idx;
    logic [1:0] b_fault_cnt;
    logic [NT-1:0] b_t_start, b_t_rval, b_t_busy;
    logic [DW-1:0] b_t_rdat, b_m_wdat;
    logic [AW-1:0] b_m_addr;

    mmv_ram_test_sequencer #(
        .AWIDTH(AW), .DWIDTH(DW), .NTESTS(NT), .STOP_ON_FAULT(1), .FCWIDTH(16)
    ) dut_a (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start),
        .ready_o(a_ready), .done_o(a_done), .fault_o(a_fault),
        .fault_idx_o(a_fault_idx), .fault_cnt_o(a_fault_cnt),
        .t_start_o(a_t_start), .t_clear_o(a_t_clear),
        .t_ready_i(t_ready), .t_fault_i(t_fault), .t_done_i(t_done),
        .t_addr_i(t_addr), .t_wdat_i(t_wdat), .t_wreq_i(t_wreq), .t_rreq_i(t_rreq),
        .t_rdat_o(a_t_rdat), .t_rval_o(a_t_rval), .t_busy_o(a_t_busy),
        .m_addr_o(a_m_addr), .m_wreq_o(a_m_wreq), .m_wdat_o(a_m_wdat), .m_rreq_o(a_m_rreq),
        .m_rdat_i(m_rdat), .m_rval_i(m_rval), .m_busy_i(m_busy)
    );

    mmv_ram_test_sequencer #(
        .AWIDTH(AW), .DWIDTH(DW), .NTESTS(NT), .STOP_ON_FAULT(0), .FCWIDTH(2)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start),
        .ready_o(b_ready), .done_o(b_done), .fault_o(b_fault),
        .fault_idx_o(b_fault_idx), .fault_cnt_o(b_fault_cnt),
        .t_start_o(b_t_start), .t_clear_o(b_t_clear),
        .t_ready_i(t_ready), .t_fault_i(t_fault), .t_done_i(t_done),
        .t_addr_i(t_addr), .t_wdat_i(t_wdat), .t_wreq_i(t_wreq), .t_rreq_i(t_rreq),
        .t_rdat_o(b_t_rdat), .t_rval_o(b_t_rval), .t_busy_o(b_t_busy),
        .m_addr_o(b_m_addr), .m_wreq_o(b_m_wreq), .m_wdat_o(b_m_wdat), .m_rreq_o(b_m_rreq),
        .m_rdat_i(m_rdat), .m_rval_i(m_rval), .m_busy_i(m_busy)
    );

    typedef struct packed {
        logic        fault;
        logic [1:0]  idx;
        logic [15:0] cnt;
    } status_t;

    int checks = 0;
    int failures = 0;
    int exp_start_q[$];
    status_t exp_done_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NT-1:0] get_tstart(input bit sel);
        return sel ? b_t_start : a_t_start;
    endfunction

    // Wait (bounded) for a tester start pulse and compare with the scoreboard.
    task automatic expect_start(input bit sel, input int budget, input string tag);
        logic [NT-1:0] ts;
        logic [31:0] exp_oh;
        int n;
        n = 0;
        ts = get_tstart(sel);
        while (ts == '0 && n < budget) begin
            step();
            n++;
            ts = get_tstart(sel);
        end
        exp_oh = '1;
        if (exp_start_q.size() > 0) exp_oh = 32'(1) << exp_start_q.pop_front();
        check_eq(tag, 32'(ts), exp_oh);
    endtask

    // Wait (bounded) for the run-done pulse and compare the run status.
    task automatic expect_done(input bit sel, input int budget, input string tag);
        status_t st;
        logic d;
        int n;
        n = 0;
        d = sel ? b_done : a_done;
        while (!d && n < budget) begin
            step();
            n++;
            d = sel ? b_done : a_done;
        end
        st = '1;
        if (exp_done_q.size() > 0) st = exp_done_q.pop_front();
        check_eq({tag, "_done"}, 32'(d), 1);
        check_eq({tag, "_fault"}, 32'(sel ? b_fault : a_fault), 32'(st.fault));
        check_eq({tag, "_idx"}, 32'(sel ? b_fault_idx : a_fault_idx), 32'(st.idx));
        check_eq({tag, "_cnt"}, 32'(sel ? 16'(b_fault_cnt) : a_fault_cnt), 32'(st.cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; start = 1'b0;
        t_ready = '1; t_fault = '0; t_done = '0; t_wreq = '0; t_rreq = '0;
        t_addr = '0; t_wdat = '0; m_rdat = '0; m_rval = 1'b0; m_busy = 1'b0;
        step();
        clear = 1'b1;
        #1;
        check_eq("rst_tclear", 32'(a_t_clear), 0);
        step();
        clear = 1'b0;
        reset = 1'b0;
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_done(input int i);
        t_done[i] = 1'b1;
        step();
        t_done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NT-1:0] seen;
        logic any_done;

        // Reset state and normal three-tester run.
        do_reset();
        check_eq("rst_ready", 32'(a_ready), 1);
        check_eq("rst_done", 32'(a_done), 0);
        check_eq("rst_fault", 32'(a_fault), 0);
        check_eq("rst_cnt", 32'(a_fault_cnt), 0);
        check_eq("rst_tstart", 32'(a_t_start), 0);
        check_eq("rst_tbusy", 32'(a_t_busy), 'h7);
        check_eq("rst_trval", 32'(a_t_rval), 0);
        check_eq("rst_mwreq", 32'(a_m_wreq), 0);
        exp_start_q.push_back(0);
        start_run();
        expect_start(0, 4, "s1_start0");
        step();
        step();
        exp_start_q.push_back(1);
        pulse_done(0);
        expect_start(0, 0, "s1_start1");
        step();
        step();
        exp_start_q.push_back(2);
        pulse_done(1);
        expect_start(0, 0, "s1_start2");
        step();
        exp_done_q.push_back('{fault: 1'b0, idx: 2'd0, cnt: 16'd0});
        pulse_done(2);
        expect_done(0, 0, "s1");
        step();
        check_eq("s1_ready", 32'(a_ready), 1);
        check_eq("s1_done_once", 32'(a_done), 0);

        // Stop on fault: tester 1 faults twice, run aborts.
        do_reset();
        exp_start_q.push_back(0);
        start_run();
        expect_start(0, 4, "s2_start0");
        step();
        exp_start_q.push_back(1);
        pulse_done(0);
        expect_start(0, 0, "s2_start1");
        step();
        t_fault[1] = 1'b1;
        step();
        t_fault = '0;
        check_eq("s2_tclear", 32'(a_t_clear), 1);
        check_eq("s2_fault", 32'(a_fault), 1);
        check_eq("s2_idx", 32'(a_fault_idx), 1);
        check_eq("s2_cnt1", 32'(a_fault_cnt), 1);
        check_eq("s2_nodone", 32'(a_done), 0);
        exp_done_q.push_back('{fault: 1'b1, idx: 2'd1, cnt: 16'd1});
        step();
        expect_done(0, 0, "s2");
        check_eq("s2_tclear_off", 32'(a_t_clear), 0);
        t_fault[1] = 1'b1;
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            t_fault = '0;
            seen = seen | a_t_start;
        end
        check_eq("s2_cnt_hold", 32'(a_fault_cnt), 1);
        check_eq("s2_no_tstart", 32'(seen), 0);
        check_eq("s2_ready", 32'(a_ready), 1);

        // No stop on fault: testers 0 and 2 fault, all three run.
        do_reset();
        exp_start_q.push_back(0);
        start_run();
        expect_start(1, 4, "s3_start0");
        step();
        t_fault = 3'b011;
        step();
        t_fault = '0;
        check_eq("s3_fault", 32'(b_fault), 1);
        check_eq("s3_idx0", 32'(b_fault_idx), 0);
        check_eq("s3_cnt1", 32'(b_fault_cnt), 1);
        exp_start_q.push_back(1);
        pulse_done(0);
        expect_start(1, 0, "s3_start1");
        step();
        exp_start_q.push_back(2);
        pulse_done(1);
        expect_start(1, 0, "s3_start2");
        step();
        t_fault[2] = 1'b1;
        step();
        t_fault = '0;
        check_eq("s3_cnt2", 32'(b_fault_cnt), 2);
        check_eq("s3_idx_first", 32'(b_fault_idx), 0);
        exp_done_q.push_back('{fault: 1'b1, idx: 2'd0, cnt: 16'd2});
        pulse_done(2);
        expect_done(1, 0, "s3");
        step();
        step();
        check_eq("s3_fault_hold", 32'(b_fault), 1);
        check_eq("s3_cnt_hold", 32'(b_fault_cnt), 2);
        start_run();
        check_eq("s3_fault_clr", 32'(b_fault), 0);
        check_eq("s3_cnt_clr", 32'(b_fault_cnt), 0);

        // Port isolation while tester 1 runs, then clear+start mid-run.
        do_reset();
        exp_start_q.push_back(0);
        start_run();
        expect_start(0, 4, "s4_start0");
        step();
        exp_start_q.push_back(1);
        pulse_done(0);
        expect_start(0, 0, "s4_start1");
        step();
        t_addr = {8'h00, 8'hA3, 8'h55};
        t_wdat = {8'h00, 8'h3C, 8'hEE};
        t_wreq = 3'b011;
        m_rdat = 8'h99;
        m_rval = 1'b1;
        m_busy = 1'b0;
        #1;
        check_eq("s4_maddr", 32'(a_m_addr), 'hA3);
        check_eq("s4_mwdat", 32'(a_m_wdat), 'h3C);
        check_eq("s4_mwreq", 32'(a_m_wreq), 1);
        check_eq("s4_mrreq", 32'(a_m_rreq), 0);
        check_eq("s4_tbusy", 32'(a_t_busy), 'h5);
        check_eq("s4_trval", 32'(a_t_rval), 'h2);
        check_eq("s4_trdat", 32'(a_t_rdat), 'h99);
        m_busy = 1'b1;
        t_wreq = 3'b001;
        t_rreq = 3'b010;
        #1;
        check_eq("s4_tbusy_hi", 32'(a_t_busy), 'h7);
        check_eq("s4_mrreq_hi", 32'(a_m_rreq), 1);
        check_eq("s4_mwreq_lo", 32'(a_m_wreq), 0);
        clear = 1'b1;
        start = 1'b1;
        #1;
        check_eq("s4_tclear", 32'(a_t_clear), 1);
        step();
        clear = 1'b0;
        start = 1'b0;
        #1;
        check_eq("s4_tclear_once", 32'(a_t_clear), 0);
        check_eq("s4_ready", 32'(a_ready), 1);
        check_eq("s4_idle_maddr", 32'(a_m_addr), 0);
        check_eq("s4_idle_mwreq", 32'(a_m_wreq), 0);
        check_eq("s4_idle_trval", 32'(a_t_rval), 0);
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            any_done = any_done | a_done;
            step();
        end
        check_eq("s4_nodone", 32'(any_done), 0);
        t_wreq = '0;
        t_rreq = '0;
        m_rval = 1'b0;
        exp_start_q.push_back(0);
        start_run();
        expect_start(0, 0, "s4_restart");

        // Tester 0 not ready for 5 cycles, then fault-counter saturation.
        do_reset();
        t_ready = 3'b110;
        start_run();
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | b_t_start;
            step();
        end
        check_eq("s5_hold", 32'(seen), 0);
        t_ready = '1;
        #1;
        exp_start_q.push_back(0);
        expect_start(1, 0, "s5_start0");
        step();
        check_eq("s5_single", 32'(b_t_start), 0);
        for (int i = 0; i < 5; i++) begin
            t_fault[0] = 1'b1;
            step();
            t_fault = '0;
            step();
        end
        check_eq("s5_sat", 32'(b_fault_cnt), 3);
        check_eq("s5_fault", 32'(b_fault), 1);
        check_eq("s5_idx", 32'(b_fault_idx), 0);

        check_eq("sb_empty", 32'(exp_start_q.size() + exp_done_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
